// File: rtl/tagged_data_fifo.sv
// First-word fall-through FIFO for {id, data} records with valid/ready on both sides.
// Optional ID filter (define TAGGED_FIFO_ID_FILTER_EN) discards non-matching records and counts them.
module tagged_data_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [ID_WIDTH-1:0]          in_id,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [ID_WIDTH-1:0]          out_id,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef TAGGED_FIFO_ID_FILTER_EN
    ,
    input  logic [ID_WIDTH-1:0]          id_mask,
    input  logic [ID_WIDTH-1:0]          id_match,
    output logic [15:0]                  drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = DATA_WIDTH + ID_WIDTH;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [RW-1:0] mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          push, pop, keep, store;
    logic [RW-1:0] head_rec;

    // Ready depends only on stored state so the producer never sees a combinational loop.
    assign in_ready  = (count_reg != FULL_COUNT);
    assign out_valid = (count_reg != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

`ifdef TAGGED_FIFO_ID_FILTER_EN
    logic [15:0] drop_cnt_reg;

    assign keep     = (((in_id ^ id_match) & id_mask) == '0);
    assign drop_cnt = drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_reg <= '0;
        end else if (push && !keep && drop_cnt_reg != 16'hFFFF) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end
`else
    assign keep = 1'b1;
`endif

    // A filtered record completes its handshake but never touches storage.
    assign store = push & keep;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (store) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({store, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is deliberately left uncleared by reset; emptiness masks stale contents.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_reg[wr_ptr_reg] <= {in_id, in_data};
        end
    end

    // Fall-through head read: the record is visible as soon as count becomes non-zero.
    assign head_rec = mem_reg[rd_ptr_reg];
    assign out_id   = out_valid ? head_rec[RW-1:DATA_WIDTH] : '0;
    assign out_data = out_valid ? head_rec[DATA_WIDTH-1:0]  : '0;
    assign count    = count_reg;

endmodule
